// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the fetch-side PC sequencer.
// State encoding and reset/increment defaults.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] DEF_INIT_VALUE = 32'h0000_0000;
  localparam logic [31:0] DEF_INC        = 32'd4;

endpackage

// File: rtl/pc_state_reg.sv
// n-bit program counter register.
// Async active-high reset to INIT_VALUE, synchronous load enable.
module pc_state_reg #(
  parameter int unsigned     N          = 32,
  parameter logic [N-1:0]    INIT_VALUE = '0
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)       r_q <= INIT_VALUE;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues req/ack instruction reads
// and hands fetched words to decode over valid/ready.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int unsigned  n          = 32,
  parameter logic [n-1:0] INIT_VALUE = n'(DEF_INIT_VALUE),
  parameter logic [n-1:0] INC        = n'(DEF_INC)
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Stall,
  input  logic         BranchTaken,
  input  logic [n-1:0] BranchTarget,
  output logic         MemReq,
  output logic [n-1:0] MemAddr,
  input  logic         MemAck,
  input  logic [31:0]  MemData,
  output logic         InstrValid,
  output logic [31:0]  Instr,
  output logic [n-1:0] InstrPc,
  input  logic         InstrReady
);

  state_t       r_state, w_state_nxt;
  logic [n-1:0] w_pc;
  logic         w_pc_load;
  logic [n-1:0] w_pc_nxt;

  logic         r_mem_req,   w_mem_req_nxt;
  logic [n-1:0] r_mem_addr,  w_mem_addr_nxt;
  logic         r_valid,     w_valid_nxt;
  logic [31:0]  r_instr,     w_instr_nxt;
  logic [n-1:0] r_instr_pc,  w_instr_pc_nxt;
  logic         r_pending,   w_pending_nxt;
  logic [n-1:0] r_target,    w_target_nxt;

  pc_state_reg #(
    .N          (n),
    .INIT_VALUE (INIT_VALUE)
  ) u_pc (
    .i_clk  (Clk),
    .i_rst  (Reset),
    .i_load (w_pc_load),
    .i_d    (w_pc_nxt),
    .o_q    (w_pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_load      = 1'b0;
    w_pc_nxt       = w_pc;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_valid_nxt    = r_valid;
    w_instr_nxt    = r_instr;
    w_instr_pc_nxt = r_instr_pc;
    w_pending_nxt  = r_pending;
    w_target_nxt   = r_target;
    unique case (r_state)
      IDLE: begin
        if (BranchTaken) begin
          w_pc_load = 1'b1;
          w_pc_nxt  = BranchTarget;
        end else if (!Stall) begin
          w_mem_addr_nxt = w_pc;
          w_mem_req_nxt  = 1'b1;
          w_state_nxt    = REQ;
        end
      end
      REQ: begin
        if (MemAck) begin
          w_mem_req_nxt = 1'b0;
          w_pc_load     = 1'b1;
          // A redirect seen during the read (or right now) voids the data
          if (BranchTaken || r_pending) begin
            w_pc_nxt      = BranchTaken ? BranchTarget : r_target;
            w_pending_nxt = 1'b0;
            w_state_nxt   = IDLE;
          end else begin
            w_instr_nxt    = MemData;
            w_instr_pc_nxt = w_pc;
            w_valid_nxt    = 1'b1;
            w_pc_nxt       = w_pc + INC;
            w_state_nxt    = HOLD;
          end
        end else if (BranchTaken) begin
          w_target_nxt  = BranchTarget;
          w_pending_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (BranchTaken) begin
          w_valid_nxt = 1'b0;
          w_pc_load   = 1'b1;
          w_pc_nxt    = BranchTarget;
          w_state_nxt = IDLE;
        end else if (InstrReady) begin
          w_valid_nxt = 1'b0;
          if (!Stall) begin
            w_mem_addr_nxt = w_pc;
            w_mem_req_nxt  = 1'b1;
            w_state_nxt    = REQ;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_mem_req  <= 1'b0;
      r_mem_addr <= INIT_VALUE;
      r_valid    <= 1'b0;
      r_instr    <= '0;
      r_instr_pc <= '0;
      r_pending  <= 1'b0;
      r_target   <= '0;
    end else begin
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_valid    <= w_valid_nxt;
      r_instr    <= w_instr_nxt;
      r_instr_pc <= w_instr_pc_nxt;
      r_pending  <= w_pending_nxt;
      r_target   <= w_target_nxt;
    end
  end

  assign MemReq     = r_mem_req;
  assign MemAddr    = r_mem_addr;
  assign InstrValid = r_valid;
  assign Instr      = r_instr;
  assign InstrPc    = r_instr_pc;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios with literal
// expectations, then random traffic against a transaction-level model.
module tb_pc_fetch_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Stall = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = '0;
  logic        MemAck = 1'b0;
  logic [31:0] MemData = '0;
  logic        InstrReady = 1'b0;

  logic        a_req, b_req, a_val, b_val;
  logic [31:0] a_addr, b_addr, a_ins, b_ins, a_ipc, b_ipc;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_fetch_sequencer u_dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .MemReq(a_req), .MemAddr(a_addr), .MemAck(MemAck),
    .MemData(MemData), .InstrValid(a_val), .Instr(a_ins),
    .InstrPc(a_ipc), .InstrReady(InstrReady)
  );

  pc_fetch_sequencer #(.INIT_VALUE(32'hFFFF_FFFC)) u_wrap (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .MemReq(b_req), .MemAddr(b_addr), .MemAck(MemAck),
    .MemData(MemData), .InstrValid(b_val), .Instr(b_ins),
    .InstrPc(b_ipc), .InstrReady(InstrReady)
  );

  // Transaction-level view: a read in flight, a word held, or neither.
  typedef struct {
    logic        busy;
    logic [31:0] addr;
    logic        held;
    logic [31:0] word;
    logic [31:0] wpc;
    logic [31:0] pc;
    logic        redirect;
    logic [31:0] dest;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t fresh(input logic [31:0] init);
    mdl_t m;
    m.busy = 0; m.addr = init; m.held = 0; m.word = 0;
    m.wpc = 0; m.pc = init; m.redirect = 0; m.dest = 0;
    return m;
  endfunction

  function automatic mdl_t step(input mdl_t m);
    mdl_t r = m;
    if (m.busy) begin
      if (MemAck) begin
        r.busy = 0;
        if (BranchTaken || m.redirect) begin
          r.pc = BranchTaken ? BranchTarget : m.dest;
          r.redirect = 0;
        end else begin
          r.held = 1; r.word = MemData; r.wpc = m.pc;
          r.pc = m.pc + 32'd4;
        end
      end else if (BranchTaken) begin
        r.redirect = 1; r.dest = BranchTarget;
      end
    end else if (m.held) begin
      if (BranchTaken) begin
        r.held = 0; r.pc = BranchTarget;
      end else if (InstrReady) begin
        r.held = 0;
        if (!Stall) begin r.busy = 1; r.addr = m.pc; end
      end
    end else begin
      if (BranchTaken) r.pc = BranchTarget;
      else if (!Stall) begin r.busy = 1; r.addr = m.pc; end
    end
    return r;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ma = fresh(32'h0);
      mb = fresh(32'hFFFF_FFFC);
    end else begin
      ma = step(ma);
      mb = step(mb);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic compare();
    chk("a.MemReq", 32'(a_req), 32'(ma.busy));
    if (ma.busy) chk("a.MemAddr", a_addr, ma.addr);
    chk("a.InstrValid", 32'(a_val), 32'(ma.held));
    if (ma.held) begin
      chk("a.Instr", a_ins, ma.word);
      chk("a.InstrPc", a_ipc, ma.wpc);
    end
    chk("b.MemReq", 32'(b_req), 32'(mb.busy));
    if (mb.busy) chk("b.MemAddr", b_addr, mb.addr);
    chk("b.InstrValid", 32'(b_val), 32'(mb.held));
    if (mb.held) begin
      chk("b.Instr", b_ins, mb.word);
      chk("b.InstrPc", b_ipc, mb.wpc);
    end
  endtask

  // Drive one cycle's inputs at a negedge, advance to the next negedge.
  task automatic cyc(input logic st, input logic bt,
                     input logic [31:0] tg, input logic ack,
                     input logic [31:0] dat, input logic rdy);
    Stall = st; BranchTaken = bt; BranchTarget = tg;
    MemAck = ack; MemData = dat; InstrReady = rdy;
    @(negedge Clk);
    compare();
  endtask

  initial begin
    logic [31:0] held_i, held_p;
    repeat (2) @(negedge Clk);
    chk("rst.MemReq", 32'(a_req), 32'd0);
    chk("rst.MemAddr", a_addr, 32'h0);
    chk("rst.InstrValid", 32'(a_val), 32'd0);
    chk("rst.Instr", a_ins, 32'h0);
    chk("rst.wrap.MemAddr", b_addr, 32'hFFFF_FFFC);
    Reset = 1'b0;

    // first fetch and accept
    cyc(0, 0, 0, 0, 0, 0);
    chk("f1.MemReq", 32'(a_req), 32'd1);
    chk("f1.MemAddr", a_addr, 32'h0);
    chk("f1.wrap.MemAddr", b_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 1, 32'hDEAD_BEEF, 1);
    chk("f1.InstrValid", 32'(a_val), 32'd1);
    chk("f1.Instr", a_ins, 32'hDEAD_BEEF);
    chk("f1.InstrPc", a_ipc, 32'h0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("f2.MemAddr", a_addr, 32'h4);
    chk("f2.wrap.MemAddr", b_addr, 32'h0);

    // stall in IDLE, then stall during REQ
    cyc(1, 0, 0, 1, 32'h1111_1111, 0);
    cyc(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("stall.idle.MemReq", 32'(a_req), 32'd0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall.resume.MemAddr", a_addr, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      chk("stall.req.MemReq", 32'(a_req), 32'd1);
    end
    cyc(1, 0, 0, 1, 32'h2222_2222, 0);
    chk("stall.req.InstrPc", a_ipc, 32'h8);

    // redirect two cycles before the ack
    cyc(0, 0, 0, 0, 0, 1);
    chk("br.MemAddr", a_addr, 32'hC);
    cyc(0, 1, 32'h100, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h3333_3333, 0);
    chk("br.discard.InstrValid", 32'(a_val), 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("br.MemAddr", a_addr, 32'h100);

    // same-cycle redirect beats the pending one
    cyc(0, 1, 32'h100, 0, 0, 0);
    cyc(0, 1, 32'h200, 1, 32'h4444_4444, 0);
    chk("br2.InstrValid", 32'(a_val), 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("br2.MemAddr", a_addr, 32'h200);

    // hold, then squash with redirect
    cyc(0, 0, 0, 1, 32'h1234_5678, 0);
    held_i = a_ins; held_p = a_ipc;
    chk("hold.Instr", a_ins, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk("hold.stable.Instr", a_ins, held_i);
      chk("hold.stable.InstrPc", a_ipc, held_p);
    end
    cyc(0, 1, 32'h40, 0, 0, 1);
    chk("squash.InstrValid", 32'(a_val), 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("squash.MemAddr", a_addr, 32'h40);

    // asynchronous reset in the middle of a read
    #2 Reset = 1'b1;
    #1;
    chk("arst.MemReq", 32'(a_req), 32'd0);
    chk("arst.MemAddr", a_addr, 32'h0);
    chk("arst.wrap.MemAddr", b_addr, 32'hFFFF_FFFC);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 4) == 0,
          ($urandom % 8) == 0,
          $urandom & 32'hFFFF_FFFC,
          ($urandom % 2) == 0,
          $urandom,
          ($urandom % 5) < 3);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
